fir_tap_scheduler: RTL and testbench
====================================

# fir_tap_scheduler

Time-multiplexed FIR controller for the low-pass filter path: shares one signed multiply-accumulate unit across `NUM_TAPS` taps. It accepts one input sample per handshake into a circular delay line and sequences one tap product per cycle, then presents the filtered result. A configuration port loads the coefficient register file.

## Interface
- `DATA_WIDTH`, 16, signed sample and coefficient width
- `ACCUM_WIDTH`, 32, signed accumulator and output width
- `NUM_TAPS`, 8, filter length; must be ≥2
- `ADDR_WIDTH`, `$clog2(NUM_TAPS)`, tap index width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `x_in`  in  DATA_WIDTH  signed input sample
- `x_valid`  in  1  sample offered
- `x_ready`  out  1  scheduler can accept a sample
- `coef_we`  in  1  coefficient write strobe
- `coef_addr`  in  ADDR_WIDTH  tap index k (0 applies to the newest sample)
- `coef_data`  in  DATA_WIDTH  signed coefficient
- `cfg_err`  out  1  one-cycle pulse: write dropped (busy or addr ≥ NUM_TAPS)
- `y_out`  out  ACCUM_WIDTH  signed filter result, held until the next result
- `y_valid`  out  1  one-cycle pulse, y_out updated
- `busy`  out  1  MAC sequence in progress

## Operation
- FSM states: IDLE, MAC, DONE.
- IDLE: `x_ready`=1. On `x_valid & x_ready`: write `x_in` to `dline[wr_ptr]`, clear acc, set tap=0, go to MAC.
- MAC: each cycle acc += coef[tap] * dline[(wr_ptr − tap) mod NUM_TAPS], with wr_ptr being the slot just written. tap increments. After tap = NUM_TAPS−1: go to DONE, advance wr_ptr modulo NUM_TAPS.
- DONE: y_out ← final acc, y_valid=1, go to IDLE.
- Arithmetic: product is full 2·DATA_WIDTH signed, sign-extended or truncated to ACCUM_WIDTH. Accumulation wraps two's-complement; no saturation.
- Coefficient write: accepted only in IDLE with coef_addr < NUM_TAPS, and takes effect next cycle. Otherwise the write is ignored and cfg_err pulses. A write in the same cycle as a sample handshake is accepted, and the new value is used by that sample's MAC.
- wr_ptr wraps NUM_TAPS−1 → 0. The delay-line read index wraps modulo NUM_TAPS. For non-power-of-2 NUM_TAPS, use explicit compare, not bit truncation.
- x_valid outside IDLE: ignored. The sample is not lost; the source holds it per valid/ready rules.
- Reset, including mid-MAC: state IDLE, delay line and coefficients all zero, wr_ptr=0, acc=0, y_out=0, y_valid=0, cfg_err=0, busy=0, x_ready=1 from the first cycle after reset deasserts. No partial result is emitted.

## Timing
- Handshake at edge t (IDLE). MAC occupies cycles t+1 … t+NUM_TAPS, with busy=1 and x_ready=0.
- DONE at t+NUM_TAPS+1: y_valid=1, busy=1, x_ready=0.
- IDLE at t+NUM_TAPS+2.
- Latency from sample handshake to y_valid: NUM_TAPS+1 cycles.
- Maximum throughput: one sample per NUM_TAPS+2 cycles.
- All outputs are registered except x_ready and busy, which decode directly from state.
- cfg_err asserts the cycle after the offending coef_we.

## Structure
- Shared package `fir_pkg`: state enum (IDLE/MAC/DONE), default DATA_WIDTH/ACCUM_WIDTH/NUM_TAPS, and the product-to-accumulator extension function.
- One natural sub-module, `fir_mac_unit`:
  - inputs: clear, enable, coef, sample
  - output: registered acc
  - contains the multiply-extend-add.
- FSM, pointers, delay line and coefficient file stay in the top.

## Test plan
- Impulse: coefs 1..8, feed 1 then seven 0s → y_out sequence 1,2,3,4,5,6,7,8; ninth sample 0 → 0.
- Wrap/overflow: all coefs 16'h7FFF, eight samples 16'h7FFF → eighth y_out = 32'hFFF80008.
- Negative: coef[0]=−2, others 0, x_in=−3 → y_out=6; x_in=16'h8000 → y_out=32'h00010000.
- Backpressure: hold x_valid=1 with a new sample each handshake → handshakes exactly 10 cycles apart; y_valid each 9 cycles after its handshake; no sample dropped or duplicated.
- Config rules:
  - coef_we during MAC → cfg_err pulses, coefficient unchanged.
  - coef_addr=8 in IDLE → cfg_err pulses.
  - write in the same cycle as a handshake → new coefficient used.
- Reset mid-MAC: assert rst at MAC cycle 4 → no y_valid; y_out=0; x_ready=1 one cycle after release; next impulse with zeroed coefs → y_out=0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR scheduler.
//   - fir_state_t    : scheduler FSM encoding (IDLE / MAC / DONE)
//   - DEF_*          : default widths and filter length
//   - extend_product : sign-extends a tap product to PROD_MAX_W bits so the
//                      caller can truncate it to any accumulator width
package fir_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_ACCUM_WIDTH = 32;
    localparam int DEF_NUM_TAPS    = 8;

    // Widest product the extension helper handles (2*DATA_WIDTH must fit).
    localparam int PROD_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } fir_state_t;

    // p holds a pw-bit two's-complement product in its low bits (upper bits
    // don't care). Shift it to the top and shift back arithmetically so that
    // bit pw-1 is replicated over the upper bits.
    function automatic logic [PROD_MAX_W-1:0] extend_product(
        input logic [PROD_MAX_W-1:0] p,
        input int                    pw
    );
        logic signed [PROD_MAX_W-1:0] t;
        t = p << (PROD_MAX_W - pw);
        return t >>> (PROD_MAX_W - pw);
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared signed multiply-accumulate for the FIR scheduler.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   clear      : zero the accumulator on the next edge (start of a sample)
//   enable     : add coef*sample into the accumulator on the next edge
//   coef       : signed coefficient for the current tap
//   sample     : signed delay-line sample for the current tap
//   acc        : registered accumulator
//   acc_sum    : acc plus the current product, i.e. the value acc takes on an
//                enabled edge; lets the top capture the final sum on the same
//                edge that performs the last accumulate
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ACCUM_WIDTH = DEF_ACCUM_WIDTH
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          enable,
    input  logic signed [DATA_WIDTH-1:0]  coef,
    input  logic signed [DATA_WIDTH-1:0]  sample,
    output logic signed [ACCUM_WIDTH-1:0] acc,
    output logic signed [ACCUM_WIDTH-1:0] acc_sum
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]          product;
    logic        [ACCUM_WIDTH-1:0] product_ext;

    // Full-precision signed product, then sign-extended (or truncated) to the
    // accumulator width. The sum wraps in two's complement; no saturation.
    assign product     = coef * sample;
    assign product_ext = ACCUM_WIDTH'(extend_product(PROD_MAX_W'($unsigned(product)), PW));
    assign acc_sum     = acc + product_ext;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc_sum;
        end
    end

endmodule

// File: rtl/fir_tap_scheduler.sv
// Time-multiplexed FIR controller: one shared MAC sequences NUM_TAPS tap
// products per input sample over a circular delay line.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   x_in, x_valid, x_ready    : sample input handshake
//   coef_we, coef_addr,
//   coef_data                 : coefficient register file write port
//   cfg_err                   : one-cycle pulse, last coefficient write dropped
//   y_out, y_valid            : filter result (held) and its one-cycle strobe
//   busy                      : MAC sequence or result presentation under way
//   dbg_state                 : current FSM state (fir_state_t encoding)
//
// Handshake: a sample transfers on a rising edge where x_valid and x_ready are
// both high. x_ready is high only in IDLE; while it is low the source keeps
// x_valid and x_in stable and the offer is simply not taken.
module fir_tap_scheduler
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ACCUM_WIDTH = DEF_ACCUM_WIDTH,
    parameter int NUM_TAPS    = DEF_NUM_TAPS,
    parameter int ADDR_WIDTH  = $clog2(NUM_TAPS)
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_WIDTH-1:0]  x_in,
    input  logic                          x_valid,
    output logic                          x_ready,
    input  logic                          coef_we,
    input  logic        [ADDR_WIDTH-1:0]  coef_addr,
    input  logic signed [DATA_WIDTH-1:0]  coef_data,
    output logic                          cfg_err,
    output logic signed [ACCUM_WIDTH-1:0] y_out,
    output logic                          y_valid,
    output logic                          busy,
    output logic        [1:0]             dbg_state
);

    // Array index width; ADDR_WIDTH may be wider so out-of-range addresses
    // can be presented and rejected.
    localparam int IDX_W = $clog2(NUM_TAPS);

    localparam logic [ADDR_WIDTH:0]   taps_ext = (ADDR_WIDTH + 1)'(NUM_TAPS);
    localparam logic [ADDR_WIDTH-1:0] last_tap = ADDR_WIDTH'(NUM_TAPS - 1);

    fir_state_t state, state_next;

    logic        [ADDR_WIDTH-1:0]  wr_ptr;
    logic        [ADDR_WIDTH-1:0]  tap;
    logic        [ADDR_WIDTH-1:0]  rd_idx;
    logic signed [DATA_WIDTH-1:0]  dline [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0]  coef  [NUM_TAPS];

    logic                          accept;
    logic                          coef_ok;
    logic                          mac_clear;
    logic                          mac_enable;
    logic signed [ACCUM_WIDTH-1:0] acc;
    logic signed [ACCUM_WIDTH-1:0] acc_sum;

    assign accept    = x_valid && x_ready;
    assign coef_ok   = (state == ST_IDLE) && ({1'b0, coef_addr} < taps_ext);
    assign dbg_state = state;

    // Tap k reads the sample written k handshakes ago: (wr_ptr - k) mod
    // NUM_TAPS, done with an explicit compare so non-power-of-2 lengths wrap
    // correctly.
    assign rd_idx = (wr_ptr >= tap) ? (wr_ptr - tap)
                                    : ADDR_WIDTH'({1'b0, wr_ptr} + taps_ext - {1'b0, tap});

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)          state_next = ST_MAC;
            ST_MAC:  if (tap == last_tap) state_next = ST_DONE;
            ST_DONE:                      state_next = ST_IDLE;
            default:                      state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        x_ready    = (state == ST_IDLE);
        busy       = (state != ST_IDLE);
        mac_clear  = accept;
        mac_enable = (state == ST_MAC);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            tap     <= '0;
            y_out   <= '0;
            y_valid <= 1'b0;
            cfg_err <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                dline[i] <= '0;
                coef[i]  <= '0;
            end
        end else begin
            y_valid <= 1'b0;
            cfg_err <= coef_we && !coef_ok;

            // A write on the handshake edge lands before the first MAC cycle,
            // so that sample already uses the new coefficient.
            if (coef_we && coef_ok) begin
                coef[IDX_W'(coef_addr)] <= coef_data;
            end

            if (accept) begin
                dline[IDX_W'(wr_ptr)] <= x_in;
                tap                   <= '0;
            end

            if (state == ST_MAC) begin
                tap <= tap + ADDR_WIDTH'(1);
                if (tap == last_tap) begin
                    wr_ptr <= (wr_ptr == last_tap) ? '0 : wr_ptr + ADDR_WIDTH'(1);
                    // Capture the final sum on the edge that enters DONE so
                    // y_out and y_valid are both registered and seen in DONE.
                    y_out   <= acc_sum;
                    y_valid <= 1'b1;
                end
            end
        end
    end

    fir_mac_unit #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ACCUM_WIDTH (ACCUM_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clear   (mac_clear),
        .enable  (mac_enable),
        .coef    (coef[IDX_W'(tap)]),
        .sample  (dline[IDX_W'(rd_idx)]),
        .acc     (acc),
        .acc_sum (acc_sum)
    );

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Self-checking bench for fir_tap_scheduler (8 taps, 16-bit data, 32-bit
// accumulator). Tap address is 4 bits wide so address 8 can be presented.
// Drivers push hand-computed results into exp_q; the monitor pops and compares
// on every y_valid and also checks handshake-to-result latency.
module tb_fir_tap_scheduler;

    localparam int DW  = 16;
    localparam int AW  = 32;
    localparam int NT  = 8;
    localparam int ADW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [DW-1:0]  x_in = '0;
    logic                  x_valid = 1'b0;
    logic                  x_ready;
    logic                  coef_we = 1'b0;
    logic        [ADW-1:0] coef_addr = '0;
    logic signed [DW-1:0]  coef_data = '0;
    logic                  cfg_err;
    logic signed [AW-1:0]  y_out;
    logic                  y_valid;
    logic                  busy;
    logic        [1:0]     dbg_state;

    fir_tap_scheduler #(
        .DATA_WIDTH  (DW),
        .ACCUM_WIDTH (AW),
        .NUM_TAPS    (NT),
        .ADDR_WIDTH  (ADW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x_in      (x_in),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .cfg_err   (cfg_err),
        .y_out     (y_out),
        .y_valid   (y_valid),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [AW-1:0] exp_q[$];
    int            hs_q[$];
    int            hs_log[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            hs_q.delete();
        end else begin
            if (x_valid && x_ready) begin
                hs_q.push_back(cyc);
                hs_log.push_back(cyc);
            end
            if (y_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_y: got y_valid with y_out=%h, expected no result", y_out);
                end else begin
                    check("y_out", y_out, exp_q.pop_front());
                end
                if (hs_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL latency: got result with no handshake, expected %0d cycles after one", NT + 1);
                end else begin
                    check("latency", 32'(cyc - hs_q.pop_front()), 32'(NT + 1));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        x_valid = 1'b0;
        coef_we = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic write_coef(input logic [ADW-1:0] addr, input logic [DW-1:0] data, input logic exp_err);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        @(posedge clk);
        #1 coef_we = 1'b0;
        @(negedge clk);
        check("cfg_err", {31'd0, cfg_err}, {31'd0, exp_err});
        @(posedge clk);
        #1;
    endtask

    // Offers a sample and waits (bounded) for it to be taken; x_valid is left
    // high so back-to-back samples keep the source continuously valid.
    task automatic issue(input logic [DW-1:0] x, input logic [AW-1:0] exp_y, input logic push);
        bit taken = 1'b0;
        if (push) exp_q.push_back(exp_y);
        x_in    = x;
        x_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (x_ready) begin
                taken = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!taken) begin
            n_tests++;
            n_fail++;
            $display("FAIL handshake: got x_ready low for 100 cycles, expected acceptance");
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        check({tag, "_y_out"},   y_out,                   32'd0);
        check({tag, "_y_valid"}, {31'd0, y_valid},        32'd0);
        check({tag, "_cfg_err"}, {31'd0, cfg_err},        32'd0);
        check({tag, "_busy"},    {31'd0, busy},           32'd0);
        check({tag, "_x_ready"}, {31'd0, x_ready},        32'd1);
        check({tag, "_state"},   {30'd0, dbg_state},      32'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [AW-1:0] wrap_exp [NT];

    initial begin
        wrap_exp = '{32'h3FFF0001, 32'h7FFE0002, 32'hBFFD0003, 32'hFFFC0004,
                     32'h3FFB0005, 32'h7FFA0006, 32'hBFF90007, 32'hFFF80008};

        // Reset state
        do_reset();
        check_idle_outputs("reset");

        // Impulse: coefs 1..8, impulse then zeros
        for (int k = 0; k < NT; k++) write_coef(ADW'(k), DW'(k + 1), 1'b0);
        issue(16'd1, 32'd1, 1'b1);
        x_valid = 1'b0;
        for (int k = 1; k < NT; k++) begin
            issue(16'd0, AW'(k + 1), 1'b1);
            x_valid = 1'b0;
        end
        issue(16'd0, 32'd0, 1'b1);
        x_valid = 1'b0;
        drain();

        // Wrap / overflow: full-scale coefs and samples
        do_reset();
        for (int k = 0; k < NT; k++) write_coef(ADW'(k), 16'h7FFF, 1'b0);
        for (int k = 0; k < NT; k++) begin
            issue(16'h7FFF, wrap_exp[k], 1'b1);
            x_valid = 1'b0;
        end
        drain();

        // Negative operands
        do_reset();
        write_coef(4'd0, 16'hFFFE, 1'b0);
        issue(16'hFFFD, 32'd6, 1'b1);
        x_valid = 1'b0;
        issue(16'h8000, 32'h00010000, 1'b1);
        x_valid = 1'b0;
        drain();

        // Backpressure: x_valid held high across four samples
        do_reset();
        write_coef(4'd0, 16'd1, 1'b0);
        write_coef(4'd1, 16'd2, 1'b0);
        hs_log.delete();
        issue(16'd5,      32'd5,   1'b1);
        issue(16'hFFF9,   32'd3,   1'b1);
        issue(16'd100,    32'd86,  1'b1);
        issue(16'd3,      32'd203, 1'b1);
        x_valid = 1'b0;
        drain();
        check("hs_count", 32'(hs_log.size()), 32'd4);
        for (int i = 1; i < hs_log.size(); i++)
            check("hs_spacing", 32'(hs_log[i] - hs_log[i-1]), 32'(NT + 2));

        // Config rules
        do_reset();
        write_coef(4'd0, 16'd1, 1'b0);
        write_coef(4'd1, 16'd1, 1'b0);
        issue(16'd10, 32'd10, 1'b1);
        x_valid = 1'b0;
        write_coef(4'd1, 16'd100, 1'b1);   // lands during MAC: dropped
        drain();
        issue(16'd20, 32'd30, 1'b1);       // 20*1 + 10*1, coef[1] unchanged
        x_valid = 1'b0;
        drain();
        write_coef(4'd8, 16'd9, 1'b1);     // out of range
        write_coef(4'd9, 16'd9, 1'b1);     // out of range
        write_coef(4'd2, 16'd3, 1'b0);
        // Write coef[0]=5 on the same edge as the handshake of sample 2:
        // 5*2 + 1*20 + 3*10 = 60
        exp_q.push_back(32'd60);
        x_in      = 16'd2;
        x_valid   = 1'b1;
        coef_we   = 1'b1;
        coef_addr = 4'd0;
        coef_data = 16'd5;
        @(negedge clk);
        check("same_cycle_ready", {31'd0, x_ready}, 32'd1);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        x_valid = 1'b0;
        @(negedge clk);
        check("same_cycle_cfg_err", {31'd0, cfg_err}, 32'd0);
        @(posedge clk);
        #1;
        drain();

        // Reset in the middle of a MAC sequence
        do_reset();
        write_coef(4'd0, 16'd7, 1'b0);
        issue(16'd3, 32'd0, 1'b0);         // aborted: no result expected
        x_valid = 1'b0;
        repeat (3) @(posedge clk);          // now in MAC cycle 4
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_idle_outputs("midmac");
        repeat (12) @(posedge clk);
        #1;
        @(negedge clk);
        check("midmac_y_out_held", y_out, 32'd0);
        @(posedge clk);
        #1;
        issue(16'd1, 32'd0, 1'b1);          // coefficients were cleared
        x_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
